// File: rtl/ps2_key_ctrl_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 key controller.
//   PS2_BREAK/PS2_EXT/PS2_ERR0/PS2_ERR1 : special scancode bytes
//   fetch_state_t : receiver handshake FSM states
//   parse_state_t : scancode prefix parser states
//   key_state_t   : held-key payload (code, valid, ext)
package ps2_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] PS2_BREAK = 8'hF0;
  localparam logic [BYTE_W-1:0] PS2_EXT   = 8'hE0;
  localparam logic [BYTE_W-1:0] PS2_ERR0  = 8'h00;
  localparam logic [BYTE_W-1:0] PS2_ERR1  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    DECODE = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    P_NORM      = 2'd0,
    P_BREAK     = 2'd1,
    P_EXT       = 2'd2,
    P_EXT_BREAK = 2'd3
  } parse_state_t;

  typedef struct packed {
    logic [BYTE_W-1:0] code;
    logic              valid;
    logic              ext;
  } key_state_t;

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// ps2_key_ctrl_if: PS/2 receiver FIFO handshake.
//   ps2_ready      : FIFO non-empty
//   ps2_data       : FIFO head byte
//   ps2_overflow   : FIFO overflow indication
//   ps2_nextdata_n : active-low pop strobe from the controller
// master = receiver side, slave = controller side.
interface ps2_key_ctrl_if;
  import ps2_pkg::*;

  logic              ps2_ready;
  logic [BYTE_W-1:0] ps2_data;
  logic              ps2_overflow;
  logic              ps2_nextdata_n;

  modport master (
    output ps2_ready,
    output ps2_data,
    output ps2_overflow,
    input  ps2_nextdata_n
  );

  modport slave (
    input  ps2_ready,
    input  ps2_data,
    input  ps2_overflow,
    output ps2_nextdata_n
  );
endinterface

// File: rtl/ps2_key_ctrl_fetch.sv
// ps2_fetch: pops one byte per pass from the PS/2 receiver FIFO.
//   clk, rst   : clock, async active-high reset
//   ready      : FIFO non-empty
//   data       : FIFO head byte, latched in IDLE when ready
//   nextdata_n : registered active-low pop strobe (one cycle, in POP)
//   byte_r     : latched byte
//   decode     : registered strobe, high during DECODE
module ps2_fetch
  import ps2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ready,
  input  logic [BYTE_W-1:0] data,
  output logic              nextdata_n,
  output logic [BYTE_W-1:0] byte_r,
  output logic              decode
);

  fetch_state_t state, state_n;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic; ready only matters in IDLE
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (ready) state_n = POP;
      POP:     state_n = DECODE;
      DECODE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs registered from the next state so they line up with POP/DECODE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nextdata_n <= 1'b1;
      decode     <= 1'b0;
      byte_r     <= '0;
    end else begin
      nextdata_n <= (state_n != POP);
      decode     <= (state_n == DECODE);
      if (state == IDLE && ready) byte_r <= data;
    end
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: turns PS/2 scancode bytes into held-key state.
// Optional feature macro: PS2_KEY_EXT_EN (E0 extended-code tracking).
//   clk, rst      : clock, async active-high reset
//   bus           : receiver FIFO handshake (slave modport)
//   key_code      : scancode of held key, 00 when none
//   key_valid     : a key is held
//   key_ext       : held key is E0-extended (0 when feature disabled)
//   press_cnt     : distinct press counter, wraps
//   press_pulse   : one-cycle pulse on a counted press
//   release_pulse : one-cycle pulse on release of the held key
//   ovf_flag      : sticky receiver overflow flag
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  ps2_key_ctrl_if.slave     bus,
  output logic [BYTE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_ext,
  output logic [CNT_W-1:0]  press_cnt,
  output logic              press_pulse,
  output logic              release_pulse,
  output logic              ovf_flag
);

  logic [BYTE_W-1:0] byte_r;
  logic              decode;

  ps2_fetch u_fetch (
    .clk        (clk),
    .rst        (rst),
    .ready      (bus.ps2_ready),
    .data       (bus.ps2_data),
    .nextdata_n (bus.ps2_nextdata_n),
    .byte_r     (byte_r),
    .decode     (decode)
  );

  parse_state_t parse_q, parse_n;
  key_state_t   key_q, key_n;
  logic [CNT_W-1:0] cnt_n;
  logic         press_n, release_n;
  logic         ext_c, brk_c, match_c;

  // Parse state, key state and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parse_q       <= P_NORM;
      key_q         <= '0;
      press_cnt     <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      ovf_flag      <= 1'b0;
    end else begin
      parse_q       <= parse_n;
      key_q         <= key_n;
      press_cnt     <= cnt_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      if (bus.ps2_overflow) ovf_flag <= 1'b1;
    end
  end

  // Parse rules applied to byte_r during DECODE
  always_comb begin
    parse_n   = parse_q;
    key_n     = key_q;
    cnt_n     = press_cnt;
    press_n   = 1'b0;
    release_n = 1'b0;
`ifdef PS2_KEY_EXT_EN
    ext_c     = (parse_q == P_EXT) || (parse_q == P_EXT_BREAK);
`else
    ext_c     = 1'b0;
`endif
    brk_c     = (parse_q == P_BREAK) || (parse_q == P_EXT_BREAK);
    match_c   = key_q.valid && (byte_r == key_q.code) && (ext_c == key_q.ext);

    if (decode) begin
      if (byte_r == PS2_BREAK) begin
`ifdef PS2_KEY_EXT_EN
        if (parse_q == P_NORM)     parse_n = P_BREAK;
        else if (parse_q == P_EXT) parse_n = P_EXT_BREAK;
`else
        parse_n = P_BREAK;
`endif
      end else if (byte_r == PS2_EXT) begin
`ifdef PS2_KEY_EXT_EN
        // E0 after F0 is malformed: drop the whole prefix
        parse_n = brk_c ? P_NORM : P_EXT;
`endif
      end else if (byte_r == PS2_ERR0 || byte_r == PS2_ERR1) begin
        parse_n = P_NORM;
      end else begin
        if (brk_c) begin
          if (match_c) begin
            key_n     = '0;
            release_n = 1'b1;
          end
        end else if (!match_c) begin
          // New make replaces any held key; a match is a typematic repeat
          key_n.code  = byte_r;
          key_n.valid = 1'b1;
          key_n.ext   = ext_c;
          cnt_n       = press_cnt + CNT_W'(1);
          press_n     = 1'b1;
        end
        parse_n = P_NORM;
      end
    end

    // Overflow wins over any prefix, including one set by this DECODE
    if (bus.ps2_overflow) parse_n = P_NORM;
  end

  assign key_code  = key_q.code;
  assign key_valid = key_q.valid;
`ifdef PS2_KEY_EXT_EN
  assign key_ext   = key_q.ext;
`else
  assign key_ext   = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Testbench for ps2_key_ctrl: FIFO emulation, reference model and scoreboard.
module tb_ps2_key_ctrl;
  import ps2_pkg::*;

  localparam int unsigned CNT_W = 8;

  typedef struct {
    logic [7:0]       code;
    logic             valid;
    logic             ext;
    logic [CNT_W-1:0] cnt;
    logic             pp;
    logic             rp;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       key_code;
  logic             key_valid;
  logic             key_ext;
  logic [CNT_W-1:0] press_cnt;
  logic             press_pulse;
  logic             release_pulse;
  logic             ovf_flag;

  ps2_key_ctrl_if bus ();

  ps2_key_ctrl #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .key_code      (key_code),
    .key_valid     (key_valid),
    .key_ext       (key_ext),
    .press_cnt     (press_cnt),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .ovf_flag      (ovf_flag)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model of the scancode parser
  logic [7:0]       m_code;
  logic             m_valid;
  logic             m_ext;
  logic [CNT_W-1:0] m_cnt;
  logic             m_brk;
  logic             m_extp;

  logic [7:0] fifo[$];
  exp_t       sb[$];
  int         pend;
  bit         prev_low;

  task automatic model_reset();
    m_code = 8'h00; m_valid = 1'b0; m_ext = 1'b0; m_cnt = '0;
    m_brk = 1'b0; m_extp = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    exp_t e;
    logic pp, rp, same;
    pp = 1'b0; rp = 1'b0;
    if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE0) begin
`ifdef PS2_KEY_EXT_EN
      if (m_brk) begin m_brk = 1'b0; m_extp = 1'b0; end
      else m_extp = 1'b1;
`endif
    end else if (b == 8'h00 || b == 8'hFF) begin
      m_brk = 1'b0; m_extp = 1'b0;
    end else begin
      same = m_valid && (m_code == b) && (m_ext == m_extp);
      if (m_brk) begin
        if (same) begin
          m_valid = 1'b0; m_code = 8'h00; m_ext = 1'b0; rp = 1'b1;
        end
      end else if (!same) begin
        m_code = b; m_valid = 1'b1; m_ext = m_extp;
        m_cnt = m_cnt + 1'b1; pp = 1'b1;
      end
      m_brk = 1'b0; m_extp = 1'b0;
    end
    e.code = m_code; e.valid = m_valid; e.ext = m_ext;
    e.cnt = m_cnt; e.pp = pp; e.rp = rp;
    fifo.push_back(b);
    sb.push_back(e);
  endtask

  // FIFO emulation and output monitor, all on the falling edge
  always @(negedge clk) begin
    exp_t e;
    bit   did;
    did = 1'b0;
    if (rst) begin
      fifo.delete();
      sb.delete();
      pend     = 0;
      prev_low = 1'b0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          did = 1'b1;
          if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("key_code", 32'(key_code), 32'(e.code));
            check("key_valid", 32'(key_valid), 32'(e.valid));
            check("key_ext", 32'(key_ext), 32'(e.ext));
            check("press_cnt", 32'(press_cnt), 32'(e.cnt));
            check("press_pulse", 32'(press_pulse), 32'(e.pp));
            check("release_pulse", 32'(release_pulse), 32'(e.rp));
          end
        end
      end
      if (!did) begin
        check("press_pulse_idle", 32'(press_pulse), 32'd0);
        check("release_pulse_idle", 32'(release_pulse), 32'd0);
      end
      if (bus.ps2_nextdata_n == 1'b0) begin
        check("pop_width", 32'(prev_low), 32'd0);
        if (fifo.size() > 0) void'(fifo.pop_front());
        pend = 2;
      end
      prev_low = (bus.ps2_nextdata_n == 1'b0);
    end
    bus.ps2_ready = (fifo.size() != 0);
    bus.ps2_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  end

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (fifo.size() == 0 && sb.size() == 0 && pend == 0) return;
    end
    check("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    bit seen;
    logic [7:0] k;
    rst = 1'b1;
    bus.ps2_overflow = 1'b0;
    model_reset();
    #1;
    check("rst_nextdata_n", 32'(bus.ps2_nextdata_n), 32'd1);
    check("rst_key_code", 32'(key_code), 32'd0);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_press_cnt", 32'(press_cnt), 32'd0);
    check("rst_ovf_flag", 32'(ovf_flag), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Pop latency: ready seen at a clock edge gives nextdata_n low for one cycle
    send(8'h1C);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      if (bus.ps2_ready) begin seen = 1'b1; break; end
    end
    if (!seen) check("ready_timeout", 32'd1, 32'd0);
    #1 check("pop_low", 32'(bus.ps2_nextdata_n), 32'd0);
    @(posedge clk);
    #1 check("pop_high", 32'(bus.ps2_nextdata_n), 32'd1);
    wait_idle(100);
    check("first_press_cnt", 32'(press_cnt), 32'd1);

    // Typematic repeats then release
    send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    wait_idle(200);
    check("repeat_cnt", 32'(press_cnt), 32'd1);
    check("released", 32'(key_valid), 32'd0);

    // Last key wins; release of a non-held key ignored
    send(8'h1C); send(8'h32); send(8'hF0); send(8'h1C);
    wait_idle(200);
    check("lastkey_code", 32'(key_code), 32'h32);
    send(8'hF0); send(8'h32);
    wait_idle(200);
    check("lastkey_cnt", 32'(press_cnt), 32'd3);

    // Extended prefix
    send(8'hE0); send(8'h75);
    wait_idle(200);
`ifdef PS2_KEY_EXT_EN
    check("ext_set", 32'(key_ext), 32'd1);
`else
    check("ext_tied", 32'(key_ext), 32'd0);
`endif
    send(8'hF0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    wait_idle(300);
    check("ext_released", 32'(key_valid), 32'd0);

    // Overflow clears a pending break prefix and sets the sticky flag
    send(8'h1C); send(8'hF0);
    wait_idle(200);
    @(negedge clk) bus.ps2_overflow = 1'b1;
    @(negedge clk) bus.ps2_overflow = 1'b0;
    m_brk = 1'b0; m_extp = 1'b0;
    check("ovf_set", 32'(ovf_flag), 32'd1);
    send(8'h1C);
    wait_idle(100);
    check("ovf_no_release", 32'(key_valid), 32'd1);
    send(8'hF0); send(8'h1C);
    wait_idle(200);

    // Counter wrap with an error byte clearing a pending break mid-stream
    for (int i = 0; i < 256; i++) begin
      k = (i % 2 == 0) ? 8'h1C : 8'h32;
      send(k);
      if (i == 100) begin
        send(8'hF0); send(8'h00); send(k);
      end
      send(8'hF0); send(k);
    end
    wait_idle(10000);
    check("wrap_cnt", 32'(press_cnt), 32'(m_cnt));
    check("ovf_sticky", 32'(ovf_flag), 32'd1);

    // Reset during POP aborts the pop asynchronously
    @(negedge clk);
    send(8'h1C);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.ps2_nextdata_n == 1'b0) begin seen = 1'b1; break; end
    end
    if (!seen) check("pop_timeout", 32'd1, 32'd0);
    rst = 1'b1;
    #1;
    check("arst_nextdata_n", 32'(bus.ps2_nextdata_n), 32'd1);
    check("arst_key_valid", 32'(key_valid), 32'd0);
    check("arst_key_code", 32'(key_code), 32'd0);
    check("arst_press_cnt", 32'(press_cnt), 32'd0);
    check("arst_ovf_flag", 32'(ovf_flag), 32'd0);
    check("arst_pulses", 32'({press_pulse, release_pulse}), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_valid", 32'(key_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
